// File: rtl/ariane_fetch_pkg.sv
// Shared AXI4 channel types, response/burst encodings and redirect causes
// for the ariane_fetch_core instruction-fetch shell.
package ariane_fetch_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 64;
  localparam int unsigned AXI_DATA_WIDTH = 64;
  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    FETCH,
    WAIT_R,
    HALT
  } fetch_state_e;

  // Listed in descending redirect priority after NONE.
  typedef enum logic [2:0] {
    NONE,
    DEBUG,
    FERR,
    IRQ_M,
    IPI,
    TIMER,
    IRQ_S
  } cause_e;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                qos;
    logic [3:0]                region;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                qos;
    logic [3:0]                region;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  function automatic logic is_fetch_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/ariane_irq_arbiter.sv
// Edge-detected interrupt pending flags, debug-mode tracking and the
// priority encoder that picks the redirect cause at each R handshake.
module ariane_irq_arbiter
  import ariane_fetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] irq_i,
  input  logic       ipi_i,
  input  logic       time_irq_i,
  input  logic       debug_req_i,
  input  logic       ferr_i,
  input  logic       take_i,
  output cause_e     cause_o,
  output logic       debug_mode_o
);

  // Bit order follows priority: M-level, software, timer, S-level.
  logic [3:0] src;
  logic [3:0] src_q;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] clr;
  logic       debug_mode_q;
  logic       debug_mode_d;

  assign src          = {irq_i[1], time_irq_i, ipi_i, irq_i[0]};
  assign debug_mode_o = debug_mode_q;

  always_comb begin
    cause_o = NONE;
    if (debug_req_i && !debug_mode_q) begin
      cause_o = DEBUG;
    end else if (ferr_i) begin
      cause_o = FERR;
    end else if (!debug_mode_q) begin
      if (pend_q[0])      cause_o = IRQ_M;
      else if (pend_q[1]) cause_o = IPI;
      else if (pend_q[2]) cause_o = TIMER;
      else if (pend_q[3]) cause_o = IRQ_S;
    end
  end

  // A new edge in the same cycle as its clear keeps the flag set.
  always_comb begin
    clr          = '0;
    debug_mode_d = debug_mode_q;
    if (take_i) begin
      unique case (cause_o)
        DEBUG:   debug_mode_d = 1'b1;
        IRQ_M:   clr[0] = 1'b1;
        IPI:     clr[1] = 1'b1;
        TIMER:   clr[2] = 1'b1;
        IRQ_S:   clr[3] = 1'b1;
        default: ;
      endcase
    end
    pend_d = (pend_q & ~clr) | (src & ~src_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q        <= '0;
      pend_q       <= '0;
      debug_mode_q <= 1'b0;
    end else begin
      src_q        <= src;
      pend_q       <= pend_d;
      debug_mode_q <= debug_mode_d;
    end
  end

endmodule

// File: rtl/ariane_fetch_core.sv
// Fetch sequencer: one 8-byte AXI4 read per beat, redirected on debug, irq and
// fetch errors. ARIANE_FETCH_ERR_HALT_EN makes a fetch error park the FSM in HALT.
module ariane_fetch_core
  import ariane_fetch_pkg::*;
#(
  parameter logic [AXI_ADDR_WIDTH-1:0] TRAP_VECTOR  = 64'h0000_0000_8000_0100,
  parameter logic [AXI_ADDR_WIDTH-1:0] DEBUG_VECTOR = 64'h0000_0000_0000_0800
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] boot_addr_i,
  input  logic [63:0] hart_id_i,
  input  logic [1:0]  irq_i,
  input  logic        ipi_i,
  input  logic        time_irq_i,
  input  logic        debug_req_i,
  output axi_req_t    axi_req_o,
  input  axi_resp_t   axi_resp_i
);

  fetch_state_e              state_q;
  fetch_state_e              state_d;
  logic [AXI_ADDR_WIDTH-1:0] pc_q;
  logic [AXI_ADDR_WIDTH-1:0] pc_d;
  logic                      ar_valid;
  logic                      r_ready;
  logic                      r_hs;
  logic                      ferr;
  logic                      debug_mode;
  cause_e                    cause;

  // Handshake: a beat transfers on the rising edge where valid && ready.
  // AR is offered only in FETCH and R only in WAIT_R, both masked during reset.
  assign ar_valid = rst_ni && (state_q == FETCH);
  assign r_ready  = rst_ni && (state_q == WAIT_R);
  assign r_hs     = axi_resp_i.r_valid && r_ready;
  assign ferr     = is_fetch_err(axi_resp_i.r.resp);

  ariane_irq_arbiter u_irq_arbiter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_i        (irq_i),
    .ipi_i        (ipi_i),
    .time_irq_i   (time_irq_i),
    .debug_req_i  (debug_req_i),
    .ferr_i       (ferr),
    .take_i       (r_hs),
    .cause_o      (cause),
    .debug_mode_o (debug_mode)
  );

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.b_ready  = 1'b1;
    axi_req_o.ar_valid = ar_valid;
    axi_req_o.r_ready  = r_ready;
    axi_req_o.ar.id    = hart_id_i[AXI_ID_WIDTH-1:0];
    axi_req_o.ar.addr  = pc_q;
    axi_req_o.ar.size  = 3'd3;
    axi_req_o.ar.burst = BURST_INCR;
    axi_req_o.ar.cache = 4'b0010;
    axi_req_o.ar.prot  = 3'b100;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      FETCH: begin
        if (ar_valid && axi_resp_i.ar_ready) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (r_hs) begin
          state_d = FETCH;
          unique case (cause)
            NONE:    pc_d = pc_q + AXI_ADDR_WIDTH'(8);
            DEBUG:   pc_d = DEBUG_VECTOR;
            default: pc_d = TRAP_VECTOR;
          endcase
`ifdef ARIANE_FETCH_ERR_HALT_EN
          if (cause == FERR) state_d = HALT;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= {boot_addr_i[63:3], 3'b000};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Inputs a read-only fetcher never consumes.
  logic unused_inputs;
  assign unused_inputs = ^{hart_id_i[63:AXI_ID_WIDTH], axi_resp_i.aw_ready,
                           axi_resp_i.w_ready, axi_resp_i.b_valid, axi_resp_i.b,
                           axi_resp_i.r.id, axi_resp_i.r.data, axi_resp_i.r.last,
                           debug_mode};

endmodule

// File: tb/tb_ariane_fetch_core.sv
// Bench for ariane_fetch_core: a one-outstanding AXI read slave, an expected
// AR-address queue checked at every AR handshake, and directed scenarios.
`timescale 1ns/1ps
module tb_ariane_fetch_core;
  import ariane_fetch_pkg::*;

  localparam logic [63:0] TRAP = 64'h0000_0000_8000_0100;
  localparam logic [63:0] DBG  = 64'h0000_0000_0000_0800;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [63:0] boot_addr = '0;
  logic [63:0] hart_id = 64'h0000_0000_0000_00A5;
  logic [1:0]  irq = '0;
  logic        ipi = 1'b0;
  logic        time_irq = 1'b0;
  logic        debug_req = 1'b0;
  axi_req_t    axi_req;
  axi_resp_t   axi_resp = '0;

  ariane_fetch_core dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .boot_addr_i (boot_addr),
    .hart_id_i   (hart_id),
    .irq_i       (irq),
    .ipi_i       (ipi),
    .time_irq_i  (time_irq),
    .debug_req_i (debug_req),
    .axi_req_o   (axi_req),
    .axi_resp_i  (axi_resp)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          ar_count = 0;
  logic [63:0] exp_q[$];
  bit          ar_rdy_en = 1'b1;
  bit          r_hold = 1'b0;
  bit          r_pend = 1'b0;
  bit          ar_hs = 1'b0;
  bit          r_hs = 1'b0;
  logic [1:0]  resp_sel = RESP_OKAY;
  logic [1:0]  cur_resp = RESP_OKAY;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // ---------------- driver: one clock per call ----------------
  // Entered at a negedge; drives the slave, samples the handshakes that the
  // coming posedge will perform, then advances to the next negedge.
  task automatic tick();
    logic [35:0] got_attr;
    logic [35:0] want_attr;
    if (ar_hs) r_pend = 1'b1;
    if (r_hs)  r_pend = 1'b0;
    axi_resp.ar_ready = ar_rdy_en;
    axi_resp.r_valid  = r_pend && !r_hold;
    axi_resp.r.resp   = axi_resp.r_valid ? cur_resp : RESP_OKAY;
    axi_resp.r.data   = {$urandom, $urandom};
    axi_resp.r.id     = 4'($urandom_range(0, 15));
    axi_resp.r.last   = 1'($urandom_range(0, 1));
    axi_resp.b_valid  = 1'($urandom_range(0, 1));
    #1;
    ar_hs = rst_n && axi_req.ar_valid && axi_resp.ar_ready;
    r_hs  = rst_n && axi_resp.r_valid && axi_req.r_ready;
    if (ar_hs) begin
      ar_count++;
      cur_resp = resp_sel;
      got_attr = {axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst, axi_req.ar.lock,
                  axi_req.ar.cache, axi_req.ar.prot, axi_req.ar.qos, axi_req.ar.region,
                  axi_req.ar.id, axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready};
      want_attr = {8'd0, 3'd3, BURST_INCR, 1'b0, 4'b0010, 3'b100, 4'd0, 4'd0,
                   hart_id[3:0], 1'b0, 1'b0, 1'b1};
      check("ar_attr", 64'(got_attr), 64'(want_attr));
      if (exp_q.size() == 0) check("ar_extra", 64'(exp_q.size()), 64'd1);
      else check("ar_addr", axi_req.ar.addr, exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_ar(input int n);
    int target;
    target = ar_count + n;
    for (int i = 0; i < 200 && ar_count < target; i++) tick();
    check("ar_count_timeout", 64'(ar_count), 64'(target));
  endtask

  task automatic do_reset(input logic [63:0] boot);
    rst_n = 1'b0;
    boot_addr = boot;
    r_pend = 1'b0; r_hold = 1'b0; ar_rdy_en = 1'b1;
    resp_sel = RESP_OKAY; cur_resp = RESP_OKAY;
    irq = '0; ipi = 1'b0; time_irq = 1'b0; debug_req = 1'b0;
    ar_hs = 1'b0; r_hs = 1'b0;
    repeat (2) tick();
    check("rst_ar_valid", 64'(axi_req.ar_valid), 64'd0);
    check("rst_r_ready", 64'(axi_req.r_ready), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string tag);
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int saved;
    @(negedge clk);

    // Boot address is aligned down and fetch advances by 8.
    do_reset(64'h0000_0000_8000_0007);
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0008);
    exp_q.push_back(64'h8000_0010);
    run_until_ar(3);
    check_drained("boot_seq_drained");

    // AR stalled by ar_ready low stays stable and is accepted once.
    do_reset(64'h1000);
    ar_rdy_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ar_valid", 64'(axi_req.ar_valid), 64'd1);
      check("stall_ar_addr", axi_req.ar.addr, 64'h1000);
    end
    ar_rdy_en = 1'b1;
    exp_q.push_back(64'h1000);
    saved = ar_count;
    tick();
    check("stall_one_ar", 64'(ar_count), 64'(saved + 1));
    check("stall_wait_r", 64'(axi_req.ar_valid), 64'd0);
    exp_q.push_back(64'h1008);
    run_until_ar(1);
    check_drained("stall_drained");

    // Timer pulse while R is outstanding redirects to the trap vector.
    do_reset(64'h2000);
    r_hold = 1'b1;
    exp_q.push_back(64'h2000);
    run_until_ar(1);
    check("wait_r_ready", 64'(axi_req.r_ready), 64'd1);
    time_irq = 1'b1; tick();
    time_irq = 1'b0; tick();
    check("no_redirect_while_outstanding", 64'(axi_req.ar_valid), 64'd0);
    exp_q.push_back(TRAP);
    exp_q.push_back(TRAP + 64'd8);
    r_hold = 1'b0;
    run_until_ar(2);
    check_drained("timer_drained");

    // Debug beats a simultaneous M-irq; afterwards irq and debug are ignored.
    do_reset(64'h3000);
    r_hold = 1'b1;
    exp_q.push_back(64'h3000);
    run_until_ar(1);
    debug_req = 1'b1; irq = 2'b01;
    tick(); tick();
    exp_q.push_back(DBG);
    r_hold = 1'b0;
    run_until_ar(1);
    exp_q.push_back(DBG + 64'd8);
    exp_q.push_back(DBG + 64'd16);
    run_until_ar(2);
    debug_req = 1'b0; irq = 2'b00; tick();
    debug_req = 1'b1; irq = 2'b10; ipi = 1'b1;
    exp_q.push_back(DBG + 64'd24);
    exp_q.push_back(DBG + 64'd32);
    run_until_ar(2);
    check_drained("debug_drained");

    // Fetch errors.
    do_reset(64'h4000);
    resp_sel = RESP_SLVERR;
    exp_q.push_back(64'h4000);
    run_until_ar(1);
`ifdef ARIANE_FETCH_ERR_HALT_EN
    resp_sel = RESP_OKAY;
    saved = ar_count;
    irq = 2'b11; debug_req = 1'b1;
    repeat (8) tick();
    check("halt_ar_valid", 64'(axi_req.ar_valid), 64'd0);
    check("halt_r_ready", 64'(axi_req.r_ready), 64'd0);
    check("halt_no_ar", 64'(ar_count), 64'(saved));
`else
    resp_sel = RESP_DECERR;
    exp_q.push_back(TRAP);
    run_until_ar(1);
    resp_sel = RESP_OKAY;
    exp_q.push_back(TRAP);
    exp_q.push_back(TRAP + 64'd8);
    run_until_ar(2);
`endif
    check_drained("ferr_drained");

    // PC wrap-around, then reset while an R beat is outstanding.
    do_reset(64'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h8);
    run_until_ar(3);
    r_hold = 1'b1;
    tick();
    check("mid_wait_r_ready", 64'(axi_req.r_ready), 64'd1);
    rst_n = 1'b0; boot_addr = 64'h5000;
    tick(); tick();
    r_hold = 1'b0;
    tick();
    check("mid_rst_r_ready", 64'(axi_req.r_ready), 64'd0);
    check("mid_rst_ar_valid", 64'(axi_req.ar_valid), 64'd0);
    ar_rdy_en = 1'b0;
    rst_n = 1'b1;
    saved = ar_count;
    tick(); tick();
    check("post_rst_r_ignored", 64'(axi_req.r_ready), 64'd0);
    check("post_rst_addr", axi_req.ar.addr, 64'h5000);
    check("post_rst_no_extra", 64'(ar_count), 64'(saved));
    ar_rdy_en = 1'b1;
    exp_q.push_back(64'h5000);
    exp_q.push_back(64'h5008);
    run_until_ar(2);
    check_drained("rst_mid_drained");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
